lutram_ring: RTL
================

// Module: lutram_ring
// PURPOSE
//  Parametrised circular sample buffer built on distributed (LUT) RAM: a single-clock
//  FIFO that never blocks the writer.
//  When full, each write overwrites the oldest entry and the read side keeps returning
//  data in oldest-first order.
//  Sits between the sampler/trigger stage and the readout/UART transmitter of the capture
//  path; also usable as a plain small FIFO.
// PARAMETERS
//  WIDTH    32  data width in bits
//  DEPTH    3   address bits; capacity N = 2**DEPTH entries
//  REG_OUT  1   1: registered read (1-cycle latency); 0: combinational read (0 latency)
// PORTS
//  clk_i       in   1        system clock
//  rst_in      in   1        reset, synchronous, active-low
//  clr_i       in   1        synchronous clear of pointers/count (contents kept)
//  wr_i        in   1        push d_i (always accepted)
//  d_i         in   WIDTH    write data
//  rd_i        in   1        pop oldest entry (ignored when empty)
//  d_o         out  WIDTH    read data
//  rd_valid_o  out  1        d_o holds a popped entry this cycle
//  cnt_o       out  DEPTH+1  entries stored, 0..N
//  empty_o     out  1        cnt_o == 0
//  full_o      out  1        cnt_o == N
//  wrapped_o   out  1        sticky: an unread entry was overwritten since last clear
// BEHAVIOUR
//  Reset (rst_in=0 at posedge): wptr=rptr=0, cnt_o=0, wrapped_o=0, rd_valid_o=0, d_o=0.
//   RAM contents are not reset.
//  Clear: clr_i=1 has the same effect as reset on pointers/flags.
//   It takes priority over wr_i/rd_i in that cycle (both dropped).
//  Pointers: DEPTH bits, wrap naturally N-1 -> 0. cnt_o is a separate DEPTH+1 bit counter.
//  Write, not full: ram[wptr]<=d_i, wptr++, cnt++.
//  Write, full, no read: ram[wptr]<=d_i, wptr++, rptr++, cnt stays N, wrapped_o<=1.
//  Read, not empty:
//   REG_OUT=1: d_o<=ram[rptr] and rd_valid_o<=1 at the next edge.
//   REG_OUT=0: d_o=ram[rptr] and rd_valid_o=1 combinationally in the same cycle.
//   In both modes rptr++ and cnt-- at the edge.
//  Read, empty: ignored; rd_valid_o=0; pointers unchanged.
//   REG_OUT=1: d_o holds its last value. REG_OUT=0: d_o=0.
//  Simultaneous write+read, 0<cnt<N: both performed, cnt unchanged.
//  Simultaneous write+read, empty: write only; read dropped.
//   No same-cycle bypass: d_i is not forwarded.
//  Simultaneous write+read, full: read returns the old ram[rptr] (read-before-write).
//   Write lands in that slot, wptr++, rptr++, cnt stays N.
//   wrapped_o is NOT set, since the overwritten entry was consumed.
//  rd_valid_o when REG_OUT=1: a 1-cycle pulse per accepted pop. It is 0 in the cycle after
//   reset or clear.
//  Reset asserted mid-operation: no pop in flight survives. rd_valid_o=0 next cycle.
//  empty_o, full_o, cnt_o and wrapped_o are registered state (or decodes of it).
//   None of them depends combinationally on wr_i/rd_i.
// STRUCTURE
//  Shared package logip_mem_pkg: typedef enum {RD_COMB, RD_REG}.
//   REG_OUT maps onto it via a local constant.
//  Sub-module lutram_dp: storage only.
//   Ports: 1 sync write (clk_i, we, waddr, wdata), 1 async read (raddr -> rdata).
//   No reset.
//  Pointer/count/flag control and the optional output register live in lutram_ring.
// TESTING (WIDTH=8, DEPTH=2, N=4; run for REG_OUT=0 and 1)
//  1 Reset -> cnt_o=0, empty_o=1, full_o=0, wrapped_o=0, rd_valid_o=0, d_o=0.
//  2 Push 0x11,0x22,0x33,0x44 -> full_o=1, cnt_o=4.
//    4 pops -> 0x11,0x22,0x33,0x44 with rd_valid_o per pop (latency per REG_OUT).
//    Then empty_o=1.
//  3 Push 0x01..0x06 with no reads -> wrapped_o=1, cnt_o=4.
//    Pops return 0x03,0x04,0x05,0x06.
//  4 Full (0xA0..0xA3) + wr_i=1/rd_i=1 with d_i=0xB0 -> pop returns 0xA0, cnt_o stays 4,
//    wrapped_o stays 0. Next pops return 0xA1,0xA2,0xA3,0xB0.
//  5 Empty + wr_i=1/rd_i=1 with d_i=0x5A -> rd_valid_o=0, cnt_o=1.
//    Next pop returns 0x5A.
//  6 cnt=3 + clr_i=1 together with wr_i=1 -> cnt_o=0, empty_o=1, wrapped_o=0.
//    Write dropped. Repeat with rst_in=0 mid-pop -> rd_valid_o=0 next cycle.

Source files
------------

// File: rtl/logip_mem_pkg.sv
// logip_mem_pkg: shared definitions for the small LUT-RAM memory blocks.
//   rd_mode_e  selects how a memory block presents read data:
//              RD_COMB - combinational read, data valid in the pop cycle
//              RD_REG  - registered read, data valid one cycle after the pop
package logip_mem_pkg;

   typedef enum logic [0:0] {
      RD_COMB = 1'b0,
      RD_REG  = 1'b1
   } rd_mode_e;

endpackage

// File: rtl/lutram_ring_if.sv
// lutram_ring_if: data/handshake bundle of the circular sample buffer.
//   clr_i       synchronous clear of pointers/count/flags
//   wr_i, d_i   push request and write data (never refused)
//   rd_i        pop request (ignored when empty)
//   d_o         read data
//   rd_valid_o  d_o holds a popped entry this cycle
//   cnt_o       entries stored, 0..2**DEPTH
//   empty_o     no entries stored
//   full_o      2**DEPTH entries stored
//   wrapped_o   sticky: an unread entry was overwritten since the last clear
// The buffer takes the slave modport, its user the master modport.
interface lutram_ring_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 3
);

   logic             clr_i;
   logic             wr_i;
   logic [WIDTH-1:0] d_i;
   logic             rd_i;
   logic [WIDTH-1:0] d_o;
   logic             rd_valid_o;
   logic [DEPTH:0]   cnt_o;
   logic             empty_o;
   logic             full_o;
   logic             wrapped_o;

   modport master (
      output clr_i, wr_i, d_i, rd_i,
      input  d_o, rd_valid_o, cnt_o, empty_o, full_o, wrapped_o
   );

   modport slave (
      input  clr_i, wr_i, d_i, rd_i,
      output d_o, rd_valid_o, cnt_o, empty_o, full_o, wrapped_o
   );

endinterface

// File: rtl/lutram_ring_dp.sv
// lutram_ring_dp: storage array of the ring (distributed RAM, no reset).
//   clk_i    write clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  asynchronous read address
//   rdata_o  asynchronous read data (returns the pre-write value when
//            raddr_i == waddr_i in a write cycle)
module lutram_dp #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 3
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [DEPTH-1:0] waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [DEPTH-1:0] raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [2**DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lutram_ring.sv
// lutram_ring: circular sample buffer on distributed RAM. Single-clock FIFO whose
// writer is never blocked: a write into a full buffer overwrites the oldest entry,
// and reads keep returning data oldest-first.
//   clk_i   system clock
//   rst_in  synchronous active-low reset (RAM contents are not reset)
//   bus     lutram_ring_if slave modport (push/pop/clear, data, status)
// Parameters: WIDTH data bits, DEPTH address bits (N = 2**DEPTH entries),
// REG_OUT 1 = registered read (1-cycle latency), 0 = combinational read.
module lutram_ring
   import logip_mem_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned DEPTH   = 3,
   parameter int unsigned REG_OUT = 1
) (
   input  logic         clk_i,
   input  logic         rst_in,
   lutram_ring_if.slave bus
);

   localparam int unsigned N       = 2 ** DEPTH;
   localparam rd_mode_e    RdMode  = (REG_OUT != 0) ? RD_REG : RD_COMB;
   localparam logic [DEPTH:0] CntFull = (DEPTH + 1)'(N);

   logic [DEPTH-1:0] wptr_q, wptr_d;
   logic [DEPTH-1:0] rptr_q, rptr_d;
   logic [DEPTH:0]   cnt_q, cnt_d;
   logic             wrapped_q, wrapped_d;

   logic             empty, full;
   logic             push, pop;
   logic [WIDTH-1:0] rdata;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CntFull);

   // Clear drops both requests; a pop from an empty buffer is ignored. Gating
   // with rst_in keeps a pop from being reported in a reset cycle.
   assign push = bus.wr_i & ~bus.clr_i & rst_in;
   assign pop  = bus.rd_i & ~bus.clr_i & ~empty & rst_in;

   lutram_dp #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (push),
      .waddr_i (wptr_q),
      .wdata_i (bus.d_i),
      .raddr_i (rptr_q),
      .rdata_o (rdata)
   );

   always_comb begin
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      cnt_d     = cnt_q;
      wrapped_d = wrapped_q;
      if (bus.clr_i) begin
         wptr_d    = '0;
         rptr_d    = '0;
         cnt_d     = '0;
         wrapped_d = 1'b0;
      end else begin
         if (push) wptr_d = wptr_q + 1'b1;
         if (pop)  rptr_d = rptr_q + 1'b1;
         case ({push, pop})
            2'b10: begin
               if (full) begin
                  // Overwrite of an unread entry: drop the oldest one.
                  rptr_d    = rptr_q + 1'b1;
                  wrapped_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            2'b01:   cnt_d = cnt_q - 1'b1;
            // Push+pop (also when full): the slot being written was just consumed.
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_in) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
         wrapped_q <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         cnt_q     <= cnt_d;
         wrapped_q <= wrapped_d;
      end
   end

   if (RdMode == RD_REG) begin : g_rd_reg
      logic [WIDTH-1:0] d_q;
      logic             rd_valid_q;

      always_ff @(posedge clk_i) begin
         if (!rst_in) begin
            d_q        <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_valid_q <= pop;
            // d_o holds the last popped value between pops.
            if (pop) d_q <= rdata;
         end
      end

      assign bus.d_o        = d_q;
      assign bus.rd_valid_o = rd_valid_q;
   end else begin : g_rd_comb
      assign bus.d_o        = pop ? rdata : '0;
      assign bus.rd_valid_o = pop;
   end

   assign bus.cnt_o     = cnt_q;
   assign bus.empty_o   = empty;
   assign bus.full_o    = full;
   assign bus.wrapped_o = wrapped_q;

endmodule
